// File: rtl/row_mult_sequencer_if.sv
// rtl/row_mult_sequencer_if.sv - start/done request bus between a requester and row_mult_sequencer
interface row_mult_sequencer_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        busy;
    logic        done;

    modport master (output start, a, b, input p, busy, done);
    modport slave  (input start, a, b, output p, busy, done);
endinterface

// File: rtl/row_mult_sequencer.sv
// rtl/row_mult_sequencer.sv - 8x8 unsigned shift-add multiplier reusing one array row over eight cycles
// Optional feature macro: ZERO_SKIP_EN (zero operand finishes immediately with p=0).
module array_row (
    input  logic [7:0] a,
    input  logic       b,
    input  logic [7:0] s_in,
    output logic [7:0] s_out,
    output logic       c_out
);
    assign {c_out, s_out} = {1'b0, s_in} + (b ? {1'b0, a} : 9'd0);
endmodule

module row_mult_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    row_mult_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [2:0] cnt;
    logic [7:0] s_out;
    logic       c_out;

    array_row u_array_row (
        .a     (a_r),
        .b     (b_r[0]),
        .s_in  (hi),
        .s_out (s_out),
        .c_out (c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= 8'd0;
            b_r      <= 8'd0;
            hi       <= 8'd0;
            lo       <= 8'd0;
            cnt      <= 3'd0;
            bus.p    <= 16'd0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
`ifdef ZERO_SKIP_EN
                        if (bus.a == 8'd0 || bus.b == 8'd0) begin
                            bus.p    <= 16'd0;
                            bus.busy <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else
`endif
                        begin
                            a_r      <= bus.a;
                            b_r      <= bus.b;
                            hi       <= 8'd0;
                            lo       <= 8'd0;
                            cnt      <= 3'd0;
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Row sum LSB is a finished product bit; the rest becomes next partial sum
                    hi  <= {c_out, s_out[7:1]};
                    lo  <= {s_out[0], lo[7:1]};
                    b_r <= b_r >> 1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bus.p    <= {c_out, s_out[7:1], s_out[0], lo[7:1]};
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_mult_sequencer.sv
// tb/tb_row_mult_sequencer.sv - self-checking bench for row_mult_sequencer against a timeline model
module tb_row_mult_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    row_mult_sequencer_if bus();

    row_mult_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int zs_lat;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count edges since acceptance; done lands m_len edges later, idle one edge after that
    int          m_k = -1;
    int          m_len = 8;
    logic [15:0] m_p = 16'd0;
    logic [15:0] m_pend = 16'd0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_k = -1; m_p = 16'd0; m_busy = 1'b0; m_done = 1'b0; chk_en = 1'b1;
        end else if (m_k < 0) begin
            if (bus.start === 1'b1) begin
                m_pend = 16'(bus.a) * 16'(bus.b);
                m_len = 8;
`ifdef ZERO_SKIP_EN
                if (bus.a == 8'd0 || bus.b == 8'd0) m_len = 0;
`endif
                m_k = 0; m_busy = 1'b1; m_done = 1'b0;
                if (m_len == 0) begin m_done = 1'b1; m_p = m_pend; end
            end
        end else begin
            m_k++;
            if (m_k == m_len + 1) begin
                m_k = -1; m_busy = 1'b0; m_done = 1'b0;
            end else if (m_k == m_len) begin
                m_done = 1'b1; m_p = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_p", bus.p, m_p);
            check("model_busy", bus.busy, m_busy);
            check("model_done", bus.done, m_done);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 30) begin @(negedge clk); n++; end
        check("idle_timeout", (n < 30), 1);
    endtask

    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ep,
                      input int elat, input string nm, output logic [15:0] pfirst);
        int n = 0;
        int nb = 0;
        bit got = 1'b0;
        pfirst = 16'hxxxx;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom);
        while (!got && n < 40) begin
            @(negedge clk); n++;
            if (n == 1) pfirst = bus.p;
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        check({nm, "_latency"}, n, elat);
        check({nm, "_busy_cycles"}, nb, elat);
        check({nm, "_p"}, bus.p, ep);
        @(negedge clk);
        check({nm, "_busy_after"}, bus.busy, 0);
        check({nm, "_done_after"}, bus.done, 0);
    endtask

    initial begin
        logic [15:0] pf;
        int ndone;
        int last_done;
        int gap_bad;
`ifdef ZERO_SKIP_EN
        zs_lat = 1;
`else
        zs_lat = 9;
`endif
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;

        // Reset held two edges with start high
        repeat (2) begin
            @(negedge clk);
            check("rst_p", bus.p, 16'h0000);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
        end
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", bus.busy, 0);

        op(8'h0D, 8'h0B, 16'h008F, 9, "basic", pf);
        op(8'hFF, 8'hFF, 16'hFE01, 9, "max", pf);
        op(8'h80, 8'h02, 16'h0100, 9, "pow2", pf);
        check("pow2_p_held", pf, 16'hFE01);

        // Start while busy is ignored
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'h02; bus.b = 8'h03;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h10;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ndone++;
                check("busy_start_p", bus.p, 16'h0006);
                bus.start = 1'b0;
            end
        end
        check("busy_start_one_done", ndone, 1);
        wait_idle();

        // Reset mid-operation
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h33;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_p", bus.p, 16'h0000);
        check("abort_busy", bus.busy, 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        op(8'h55, 8'h33, 16'h10EF, 9, "after_abort", pf);

        op(8'h00, 8'h5A, 16'h0000, zs_lat, "zero_a", pf);
        op(8'hA7, 8'h00, 16'h0000, zs_lat, "zero_b", pf);

        // Start held high: one product every 10 cycles
        ndone = 0; last_done = -1; gap_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (last_done >= 0 && i - last_done != 10) gap_bad++;
                last_done = i; ndone++;
            end
            bus.start = 1'b1;
            bus.a = 8'($urandom_range(1, 255));
            bus.b = 8'($urandom_range(1, 255));
        end
        bus.start = 1'b0;
        check("throughput_gap", gap_bad, 0);
        check("throughput_count", (ndone >= 4), 1);
        wait_idle();

        // Random traffic, including zero operands and occasional reset
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rst = ($urandom_range(0, 79) == 0);
        end
        rst = 1'b0; bus.start = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
